// File: rtl/csr_file_m.sv
// Machine-mode CSR unit: decoded M-mode CSRs, RW/RS/RC access, 64-bit counters,
// trap entry and mret bookkeeping.
module csr_file_m #(
    parameter int unsigned XLEN         = 32,
    parameter bit          HAS_COUNTERS = 1'b1,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter logic [31:0] HARTID       = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_req,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instret_inc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_global
);

    localparam logic [1:0]  OP_RW = 2'b01;
    localparam logic [1:0]  OP_RS = 2'b10;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;

    logic            st_mie;
    logic            st_mpie;
    logic [XLEN-1:0] mie_r;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [63:0]     mcycle;
    logic [63:0]     minstret;
    logic [63:0]     mcycle_nxt;
    logic [63:0]     minstret_nxt;

    logic            active_c;
    logic            wr_intent_c;
    logic            mapped_c;
    logic [XLEN-1:0] old_c;
    logic [XLEN-1:0] wval_c;
    logic            we_c;
    logic [XLEN-1:0] mstatus_rd_c;
    logic [XLEN-1:0] cyc_lo_c, cyc_hi_c, ins_lo_c, ins_hi_c;

    assign mstatus_rd_c = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign cyc_lo_c     = HAS_COUNTERS ? mcycle[31:0]    : '0;
    assign cyc_hi_c     = HAS_COUNTERS ? mcycle[63:32]   : '0;
    assign ins_lo_c     = HAS_COUNTERS ? minstret[31:0]  : '0;
    assign ins_hi_c     = HAS_COUNTERS ? minstret[63:32] : '0;

    // Address decode, legality, read mux and read-modify-write value
    always_comb begin
        old_c       = '0;
        mapped_c    = 1'b1;
        active_c    = csr_req && (csr_op != 2'b00);
        wr_intent_c = (csr_op == OP_RW) || (csr_wdata != '0);
        case (csr_addr)
            A_MSTATUS:                old_c = mstatus_rd_c;
            A_MISA:                   old_c = MISA_VAL;
            A_MIE:                    old_c = mie_r;
            A_MTVEC:                  old_c = mtvec;
            A_MSCRATCH:               old_c = mscratch;
            A_MEPC:                   old_c = mepc;
            A_MCAUSE:                 old_c = mcause;
            A_MTVAL:                  old_c = mtval;
            A_MIP:                    old_c = '0;
            A_MCYCLE,   A_CYCLE:      old_c = cyc_lo_c;
            A_MCYCLEH,  A_CYCLEH:     old_c = cyc_hi_c;
            A_MINSTRET, A_INSTRET:    old_c = ins_lo_c;
            A_MINSTRETH, A_INSTRETH:  old_c = ins_hi_c;
            A_MHARTID:                old_c = HARTID;
            default:                  mapped_c = 1'b0;
        endcase
        csr_illegal = active_c && (!mapped_c || (wr_intent_c &&
                      ((csr_addr[11:10] == 2'b11) || (csr_addr == A_MISA))));
        csr_rdata   = (active_c && !csr_illegal) ? old_c : '0;
        case (csr_op)
            OP_RW:   wval_c = csr_wdata;
            OP_RS:   wval_c = old_c | csr_wdata;
            default: wval_c = old_c & ~csr_wdata;
        endcase
        // Trap and mret take precedence over any CSR write in the same cycle
        we_c = active_c && !csr_illegal && wr_intent_c && !trap_valid && !mret;
    end

    // Counter next values: a write to either half replaces it and skips the increment
    always_comb begin
        mcycle_nxt   = mcycle + 64'd1;
        minstret_nxt = instret_inc ? minstret + 64'd1 : minstret;
        if (we_c) begin
            case (csr_addr)
                A_MCYCLE:    mcycle_nxt   = {mcycle[63:32], wval_c};
                A_MCYCLEH:   mcycle_nxt   = {wval_c, mcycle[31:0]};
                A_MINSTRET:  minstret_nxt = {minstret[63:32], wval_c};
                A_MINSTRETH: minstret_nxt = {wval_c, minstret[31:0]};
                default: ;
            endcase
        end
    end

    // Trap vector: vectored mode offsets interrupts by 4*cause
    always_comb begin
        trap_vector = {mtvec[31:2], 2'b00};
        if ((mtvec[1:0] == 2'b01) && trap_cause[31])
            trap_vector = {mtvec[31:2], 2'b00} + {trap_cause[29:0], 2'b00};
    end

    assign mepc_o     = mepc;
    assign mie_global = st_mie;

    // CSR state: reset, trap entry, mret, then software writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            mie_r    <= '0;
            mtvec    <= MTVEC_RESET;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (HAS_COUNTERS) begin
                mcycle   <= mcycle_nxt;
                minstret <= minstret_nxt;
            end
            if (trap_valid) begin
                mepc    <= {trap_pc[31:2], 2'b00};
                mcause  <= trap_cause;
                mtval   <= trap_tval;
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end else if (mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (we_c) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        st_mie  <= wval_c[3];
                        st_mpie <= wval_c[7];
                    end
                    A_MIE:      mie_r    <= wval_c;
                    A_MTVEC:    mtvec    <= {wval_c[31:2], wval_c[1] ? 2'b00 : wval_c[1:0]};
                    A_MSCRATCH: mscratch <= wval_c;
                    A_MEPC:     mepc     <= {wval_c[31:2], 2'b00};
                    A_MCAUSE:   mcause   <= wval_c;
                    A_MTVAL:    mtval    <= wval_c;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_file_m.sv
// Bench for csr_file_m: directed scenarios plus randomized traffic against a
// behavioural model of the machine-mode CSR state.
module tb_csr_file_m;

    localparam logic [31:0] P_MTVEC_RESET = 32'h0000_0400;
    localparam logic [31:0] P_HARTID      = 32'h0000_0003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instret_inc;
    logic        trap_valid;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        mret;
    logic [31:0] trap_vector, mepc_o;
    logic        mie_global;

    int n_cmp = 0;
    int n_bad = 0;

    csr_file_m #(.XLEN(32), .HAS_COUNTERS(1'b1), .MTVEC_RESET(P_MTVEC_RESET), .HARTID(P_HARTID)) dut (
        .clk(clk), .rst_n(rst_n), .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .instret_inc(instret_inc), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret), .trap_vector(trap_vector),
        .mepc_o(mepc_o), .mie_global(mie_global)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;

    // Expected and observed values captured during the last step
    logic [31:0] e_rd, o_rd, e_tv, o_tv, e_mepc, o_mepc;
    logic        e_ill, o_ill, e_mieg, o_mieg;

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_mie_r = 0; m_mtvec = P_MTVEC_RESET;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a, output bit mapped);
        mapped = 1;
        case (a)
            12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie_r;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return 32'h0;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            12'hF14: return P_HARTID;
            default: begin mapped = 0; return 32'h0; end
        endcase
    endfunction

    // One clock: drive, sample combinational outputs, advance clock and model
    task automatic step(input logic req, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input logic inc, input logic tv,
                        input logic [31:0] tc, input logic [31:0] tp, input logic [31:0] tt,
                        input logic mr);
        bit mapped, active, wr, dowr, cw, iw;
        logic [31:0] old, nv;
        csr_req = req; csr_op = op; csr_addr = a; csr_wdata = wd; instret_inc = inc;
        trap_valid = tv; trap_cause = tc; trap_pc = tp; trap_tval = tt; mret = mr;
        #3;
        old    = model_read(a, mapped);
        active = req && (op != 2'b00);
        wr     = (op == 2'b01) || (wd != 0);
        e_ill  = active && (!mapped || (wr && (a[11:10] == 2'b11 || a == 12'h301)));
        e_rd   = (active && !e_ill) ? old : 32'h0;
        e_tv   = (m_mtvec[1:0] == 2'b01 && tc[31]) ? (m_mtvec & ~32'h3) + 4 * (tc & 32'h7FFF_FFFF)
                                                    : (m_mtvec & ~32'h3);
        e_mepc = m_mepc;
        e_mieg = m_mie;
        o_rd = csr_rdata; o_ill = csr_illegal; o_tv = trap_vector; o_mepc = mepc_o; o_mieg = mie_global;
        nv   = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        dowr = active && !e_ill && wr && !tv && !mr;
        cw = 0; iw = 0;
        @(posedge clk);
        if (tv) begin
            m_mepc = tp & ~32'h3; m_mcause = tc; m_mtval = tt; m_mpie = m_mie; m_mie = 0;
        end else if (mr) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (dowr) begin
            case (a)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mie_r = nv;
                12'h305: m_mtvec = nv[1] ? (nv & ~32'h3) : nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: begin m_cyc[31:0]  = nv; cw = 1; end
                12'hB80: begin m_cyc[63:32] = nv; cw = 1; end
                12'hB02: begin m_ins[31:0]  = nv; iw = 1; end
                12'hB82: begin m_ins[63:32] = nv; iw = 1; end
                default: ;
            endcase
        end
        if (!cw) m_cyc = m_cyc + 1;
        if (!iw && inc) m_ins = m_ins + 1;
        #1;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        step(1, op, a, wd, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        step(0, 2'b00, 12'h000, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0;
        step(0, 2'b00, 12'h000, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1;
        model_reset();
        csr(2'b10, 12'h305, 0);
        n_cmp++; if (o_rd !== 32'h0000_0400) begin n_bad++; $display("FAIL reset_mtvec got=%h want=%h", o_rd, 32'h0000_0400); end
        csr(2'b10, 12'hF14, 0);
        n_cmp++; if (o_rd !== P_HARTID) begin n_bad++; $display("FAIL reset_hartid got=%h want=%h", o_rd, P_HARTID); end
        csr(2'b10, 12'h301, 0);
        n_cmp++; if (o_rd !== 32'h4000_0100) begin n_bad++; $display("FAIL reset_misa got=%h want=%h", o_rd, 32'h4000_0100); end
        n_cmp++; if (o_mieg !== 1'b0 || o_mepc !== 32'h0) begin n_bad++; $display("FAIL reset_mie_mepc got=%b/%h want=0/0", o_mieg, o_mepc); end
        csr(2'b10, 12'h300, 0);
        n_cmp++; if (o_rd !== 32'h0000_1800) begin n_bad++; $display("FAIL reset_mstatus got=%h want=%h", o_rd, 32'h0000_1800); end
    endtask

    task automatic test_rmw();
        logic [31:0] want [4];
        want = '{32'h0, 32'hDEAD_BEEF, 32'hDEAD_BFFF, 32'h0000_BFFF};
        csr(2'b01, 12'h340, 32'hDEAD_BEEF);
        n_cmp++; if (o_rd !== want[0]) begin n_bad++; $display("FAIL rmw_rw got=%h want=%h", o_rd, want[0]); end
        csr(2'b10, 12'h340, 32'h0000_0110);
        n_cmp++; if (o_rd !== want[1]) begin n_bad++; $display("FAIL rmw_rs got=%h want=%h", o_rd, want[1]); end
        csr(2'b11, 12'h340, 32'hDEAD_0000);
        n_cmp++; if (o_rd !== want[2]) begin n_bad++; $display("FAIL rmw_rc got=%h want=%h", o_rd, want[2]); end
        csr(2'b10, 12'h340, 0);
        n_cmp++; if (o_rd !== want[3]) begin n_bad++; $display("FAIL rmw_final got=%h want=%h", o_rd, want[3]); end
    endtask

    task automatic test_illegal();
        logic [11:0] a [6];
        logic [1:0]  op [6];
        logic [31:0] wd [6];
        bit          il [6];
        a  = '{12'hC00, 12'hC00, 12'hF14, 12'h7C0, 12'h301, 12'h301};
        op = '{2'b01,   2'b10,   2'b01,   2'b10,   2'b01,   2'b11};
        wd = '{32'h5,   32'h0,   32'h1,   32'h0,   32'h0,   32'h0};
        il = '{1, 0, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            csr(op[i], a[i], wd[i]);
            n_cmp++; if (o_ill !== il[i] || o_ill !== e_ill) begin n_bad++; $display("FAIL illegal_%0d got=%b want=%b", i, o_ill, il[i]); end
            n_cmp++; if (o_rd !== e_rd) begin n_bad++; $display("FAIL illegal_rd_%0d got=%h want=%h", i, o_rd, e_rd); end
        end
    endtask

    task automatic test_counters();
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        csr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        csr(2'b10, 12'hB80, 0);
        n_cmp++; if (o_rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cyc_hi_set got=%h want=%h", o_rd, 32'hFFFF_FFFF); end
        csr(2'b10, 12'hC00, 0);
        n_cmp++; if (o_rd !== 32'h0) begin n_bad++; $display("FAIL cyc_wrap_lo got=%h want=0", o_rd); end
        csr(2'b10, 12'hC80, 0);
        n_cmp++; if (o_rd !== 32'h0) begin n_bad++; $display("FAIL cyc_wrap_hi got=%h want=0", o_rd); end
        csr(2'b01, 12'hB02, 32'h0000_0100);
        for (int i = 0; i < 5; i++) step(0, 2'b00, 12'h0, 0, 1, 0, 0, 0, 0, 0);
        csr(2'b10, 12'hC02, 0);
        n_cmp++; if (o_rd !== 32'h0000_0105) begin n_bad++; $display("FAIL instret_5 got=%h want=%h", o_rd, 32'h0000_0105); end
        step(1, 2'b01, 12'hB02, 32'h0000_0777, 1, 0, 0, 0, 0, 0);
        csr(2'b10, 12'hB02, 0);
        n_cmp++; if (o_rd !== 32'h0000_0777) begin n_bad++; $display("FAIL instret_wr got=%h want=%h", o_rd, 32'h0000_0777); end
    endtask

    task automatic test_trap();
        csr(2'b01, 12'h305, 32'h0000_0101);
        csr(2'b10, 12'h300, 32'h0000_0008);
        step(0, 2'b00, 12'h0, 0, 0, 1, 32'h8000_0007, 32'h0000_1236, 32'h0000_00AA, 0);
        n_cmp++; if (o_tv !== 32'h0000_011C) begin n_bad++; $display("FAIL trap_vector got=%h want=%h", o_tv, 32'h0000_011C); end
        n_cmp++; if (o_mieg !== 1'b1) begin n_bad++; $display("FAIL trap_pre_mie got=%b want=1", o_mieg); end
        csr(2'b10, 12'h300, 0);
        n_cmp++; if (o_rd !== 32'h0000_1880 || o_mepc !== 32'h0000_1234 || o_mieg !== 1'b0) begin
            n_bad++; $display("FAIL trap_state got=%h/%h/%b want=00001880/00001234/0", o_rd, o_mepc, o_mieg); end
        csr(2'b10, 12'h342, 0);
        n_cmp++; if (o_rd !== 32'h8000_0007) begin n_bad++; $display("FAIL trap_mcause got=%h want=%h", o_rd, 32'h8000_0007); end
        step(0, 2'b00, 12'h0, 0, 0, 0, 0, 0, 0, 1);
        csr(2'b10, 12'h300, 0);
        n_cmp++; if (o_rd !== 32'h0000_1888 || o_mieg !== 1'b1) begin n_bad++; $display("FAIL mret_state got=%h/%b want=00001888/1", o_rd, o_mieg); end
        step(0, 2'b00, 12'h0, 0, 0, 0, 32'h0000_0005, 0, 0, 0);
        n_cmp++; if (o_tv !== 32'h0000_0100) begin n_bad++; $display("FAIL tvec_exc got=%h want=%h", o_tv, 32'h0000_0100); end
    endtask

    task automatic test_priority();
        step(1, 2'b01, 12'h341, 32'h0000_5550, 0, 1, 32'h0000_0002, 32'h0000_2000, 32'h0, 1);
        csr(2'b10, 12'h341, 0);
        n_cmp++; if (o_rd !== 32'h0000_2000) begin n_bad++; $display("FAIL prio_mepc got=%h want=%h", o_rd, 32'h0000_2000); end
        csr(2'b10, 12'h300, 0);
        n_cmp++; if (o_rd !== 32'h0000_1880 || o_mieg !== 1'b0) begin n_bad++; $display("FAIL prio_mstatus got=%h/%b want=00001880/0", o_rd, o_mieg); end
    endtask

    task automatic test_async_reset();
        step(0, 2'b00, 12'h0, 0, 0, 0, 0, 0, 0, 1);
        csr(2'b01, 12'h340, 32'h1234_5678);
        csr_req = 1; csr_op = 2'b10; csr_addr = 12'h340; csr_wdata = 0;
        #2 rst_n = 0;
        #1;
        n_cmp++; if (mepc_o !== 32'h0 || mie_global !== 1'b0) begin n_bad++; $display("FAIL areset_out got=%h/%b want=0/0", mepc_o, mie_global); end
        n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL areset_mscratch got=%h want=0", csr_rdata); end
        csr_addr = 12'h305;
        #1;
        n_cmp++; if (csr_rdata !== P_MTVEC_RESET) begin n_bad++; $display("FAIL areset_mtvec got=%h want=%h", csr_rdata, P_MTVEC_RESET); end
        @(negedge clk); rst_n = 1;
        model_reset();
        @(posedge clk); #1;
        m_cyc = 1;
        csr(2'b10, 12'hB00, 0);
        n_cmp++; if (o_rd !== e_rd) begin n_bad++; $display("FAIL areset_cycle got=%h want=%h", o_rd, e_rd); end
    endtask

    task automatic test_random();
        logic [11:0] pool [20];
        logic [11:0] a;
        logic [31:0] wd;
        pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                 12'hC82, 12'hF14, 12'h7C0, 12'h306};
        for (int i = 0; i < 400; i++) begin
            a  = pool[$urandom_range(0, 19)];
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, wd, 1'($urandom),
                 $urandom_range(0, 15) == 0, $urandom, $urandom, $urandom, $urandom_range(0, 15) == 0);
            n_cmp++; if (o_rd !== e_rd) begin n_bad++; $display("FAIL rand_rdata[%0d] addr=%h got=%h want=%h", i, a, o_rd, e_rd); end
            n_cmp++; if (o_ill !== e_ill) begin n_bad++; $display("FAIL rand_illegal[%0d] addr=%h got=%b want=%b", i, a, o_ill, e_ill); end
            n_cmp++; if (o_tv !== e_tv) begin n_bad++; $display("FAIL rand_tvec[%0d] got=%h want=%h", i, o_tv, e_tv); end
            n_cmp++; if (o_mepc !== e_mepc || o_mieg !== e_mieg) begin
                n_bad++; $display("FAIL rand_state[%0d] got=%h/%b want=%h/%b", i, o_mepc, o_mieg, e_mepc, e_mieg); end
        end
    endtask

    initial begin
        rst_n = 0; csr_req = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0; instret_inc = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret = 0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_rmw();
        test_illegal();
        test_counters();
        test_trap();
        test_priority();
        test_async_reset();
        test_random();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
